uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: FRAME_TICKS, default 11, number of intx baud ticks per transmitted frame (start + 8 data + parity + stop).
REQ-002 Parameter: NREQ, default 4, number of requesters (fixed at 4 for this revision).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 intx  input  1  transmit baud tick from the baud generator, one clk wide.
REQ-006 req  input  4  per-requester transmit request, level, held until ack.
REQ-007 req_data  input  32  requester n byte on bits [8n+7:8n].
REQ-008 gnt  output  4  one-hot grant, registered.
REQ-009 gnt_id  output  2  binary index of the granted requester.
REQ-010 ack  output  4  one-cycle completion pulse to the granted requester.
REQ-011 tx_data  output  8  byte presented to the transmitter, stable from LOAD through DONE.
REQ-012 tx_load  output  1  one-cycle load strobe to the transmitter.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 FSM states IDLE, LOAD, SEND, DONE; encoding is free.
REQ-015 IDLE: if req != 0, the winner is sampled; next cycle enters LOAD with gnt, gnt_id and tx_data registered from the winner; if req == 0, the FSM stays in IDLE.
REQ-016 Arbitration: round-robin; the search starts at last_id+1 mod 4 and ascends with wrap, so the most recently served requester has lowest priority.
REQ-017 LOAD: tx_load=1 for exactly one cycle, tick counter cleared to 0, then unconditional transition to SEND.
REQ-018 An intx arriving in IDLE, LOAD or DONE is ignored and is not counted.
REQ-019 SEND: each intx increments the 4-bit tick counter; the intx that occurs while counter == FRAME_TICKS-1 moves the FSM to DONE.
REQ-020 DONE: ack[gnt_id]=1 for one cycle; last_id <= gnt_id; gnt cleared to 0; next state IDLE.
REQ-021 Deasserting req during LOAD/SEND does not abort; the frame completes and ack is still issued.
REQ-022 Requests in LOAD/SEND/DONE are not sampled; arbitration happens only in IDLE.
REQ-023 Minimum gap: ack in cycle T, the next tx_load in cycle T+2 (IDLE at T+1, LOAD at T+2).
REQ-024 A requester still asserting req in the cycle after its ack is treated as a new request.
REQ-025 tx_data and gnt_id hold their values from LOAD until the next LOAD; only gnt clears in DONE.
REQ-026 Frame latency: from tx_load to ack equals FRAME_TICKS intx pulses plus 2 clk cycles.

Reset
REQ-027 reset low asynchronously forces: state=IDLE, gnt=0, gnt_id=0, ack=0, tx_load=0, busy=0, tx_data=8'h00, tick counter=0, last_id=3 (so req[0] has the highest priority first).
REQ-028 Reset asserted mid-frame abandons the frame; no ack is issued for it, and after release the FSM re-arbitrates from IDLE.
REQ-029 Reset release is taken synchronously; the first arbitration occurs no earlier than the first clk edge with reset high.

Verification
REQ-030 Single request: req=4'b0100, req_data[23:16]=8'hA5, intx every 16 clk -> gnt=4'b0100, gnt_id=2, tx_data=8'hA5, one tx_load pulse, ack[2] after the 11th intx, busy low afterwards.
REQ-031 All requesting: req=4'b1111 held from reset -> grant order 0,1,2,3,0, one ack per frame, with tx_load exactly 2 cycles after each ack.
REQ-032 Fairness: req[1] and req[3] held continuously -> grants alternate 1,3,1,3; neither is granted twice in a row.
REQ-033 Spurious ticks: intx pulsed in IDLE and in the LOAD cycle -> counter unaffected; ack still only after 11 intx in SEND.
REQ-034 Request withdrawal: req[0] dropped after 3 ticks of SEND -> frame continues, ack[0] pulses after tick 11, FSM returns to IDLE.
REQ-035 Mid-frame reset: reset low after 5 ticks -> all outputs 0 immediately, no ack; after release with req=4'b0001, req[0] is regranted and a full 11-tick frame completes.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one byte at a time from four requesters to a UART transmitter.
// A frame spans LOAD, then FRAME_TICKS baud ticks in SEND, then a one-cycle DONE that acknowledges the requester.
module uart_tx_arbiter #(
    parameter int FRAME_TICKS = 11,
    parameter int NREQ        = 4,
    parameter int DATA_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     intx,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic [NREQ-1:0]          ack,
    output logic [DATA_W-1:0]        tx_data,
    output logic                     tx_load,
    output logic                     busy
);

    localparam int ID_W = $clog2(NREQ);
    localparam logic [3:0] LAST_TICK = 4'(FRAME_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [3:0]        tick_cnt;
    logic [ID_W-1:0]   last_id;
    logic [ID_W-1:0]   cand;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    logic [DATA_W-1:0] win_data;

    // Search starts just after the last served requester, so it ends up with lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = last_id + ID_W'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_load = 1'b0;
        ack     = '0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                tx_load = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                if (intx && (tick_cnt == LAST_TICK)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ack[gnt_id] = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Ticks outside SEND are deliberately ignored; tx_data and gnt_id persist until the next grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt      <= '0;
            gnt_id   <= '0;
            tx_data  <= '0;
            tick_cnt <= '0;
            last_id  <= ID_W'(NREQ - 1);
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found) begin
                        gnt     <= {{(NREQ-1){1'b0}}, 1'b1} << win_id;
                        gnt_id  <= win_id;
                        tx_data <= win_data;
                    end
                end
                LOAD: begin
                    tick_cnt <= '0;
                end
                SEND: begin
                    if (intx) begin
                        tick_cnt <= tick_cnt + 4'd1;
                    end
                end
                DONE: begin
                    gnt     <= '0;
                    last_id <= gnt_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a table of arbitration scenarios with constant expected winners,
// hand-written reset sequences, and random frames checked against a transaction-level model.
module tb_uart_tx_arbiter;

    localparam int FT = 11;

    logic        clk = 1'b0;
    logic        reset;
    logic        intx;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic [3:0]  ack;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic        busy;

    int n_total = 0;
    int n_bad   = 0;
    int cyc_n   = 0;
    int last_ack_cyc = 0;
    logic [1:0] m_last;

    uart_tx_arbiter #(.FRAME_TICKS(FT), .NREQ(4), .DATA_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .intx     (intx),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .ack      (ack),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  r;
        logic [31:0] d;
        int          gap;
        bit          b2b;
        bit          spur;
        int          period;
        int          drop_at;
        logic [1:0]  exp_id;
        logic [7:0]  exp_byte;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    // Reference arbitration: visit requesters in the order last+1, last+2, ... with wrap.
    function automatic logic [1:0] model_pick(input logic [3:0] r, input logic [1:0] last);
        int order[$];
        for (int k = 1; k <= 4; k++) order.push_back((int'(last) + k) % 4);
        foreach (order[j]) begin
            if (r[order[j]]) return 2'(order[j]);
        end
        return last;
    endfunction

    task automatic do_frame(input logic [3:0] r, input logic [31:0] d, input logic [1:0] id,
                            input logic [7:0] byt, input int gap, input bit b2b, input bit spur,
                            input int period, input int drop_at);
        int   n;
        int   k;
        int   err;
        logic t;
        logic [3:0] oh;
        oh = 4'b0001 << id;
        for (int g = 0; g < gap; g++) begin
            req  = 4'b0000;
            intx = spur ? 1'b1 : 1'($urandom_range(0, 1));
            cyc();
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_gnt", 32'(gnt), 32'd0);
        end
        chk("pre_busy", 32'(busy), 32'd0);
        req      = r;
        req_data = d;
        intx     = spur ? 1'b1 : 1'($urandom_range(0, 1));
        cyc();
        chk("load_strobe", 32'(tx_load), 32'd1);
        chk("load_gnt", 32'(gnt), 32'(oh));
        chk("load_id", 32'(gnt_id), 32'(id));
        chk("load_data", 32'(tx_data), 32'(byt));
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_ack", 32'(ack), 32'd0);
        if (b2b) chk("ack_to_load", 32'(cyc_n - last_ack_cyc), 32'd2);
        intx = spur ? 1'b1 : 1'($urandom_range(0, 1));
        cyc();
        chk("send_strobe", 32'(tx_load), 32'd0);
        n   = 0;
        k   = 0;
        err = 0;
        while (n < FT && k < 4000) begin
            if (period == 0) t = ($urandom_range(0, 2) == 0);
            else             t = ((k % period) == period - 1);
            intx = t;
            if (drop_at >= 0 && n >= drop_at) req = 4'b0000;
            else if (period == 0 && (k % 5) == 2) req = 4'($urandom);
            if ((k % 7) == 3) req_data = $urandom;
            cyc();
            k++;
            if (t) n++;
            if (n < FT) begin
                if (ack !== 4'b0000 || busy !== 1'b1 || tx_load !== 1'b0 ||
                    tx_data !== byt || gnt !== oh) err++;
            end
        end
        intx = 1'b0;
        if (n < FT) begin
            chk("frame_timeout", 32'(n), 32'(FT));
            return;
        end
        chk("send_quiet", 32'(err), 32'd0);
        chk("done_ack", 32'(ack), 32'(oh));
        chk("done_gnt", 32'(gnt), 32'(oh));
        chk("done_busy", 32'(busy), 32'd1);
        last_ack_cyc = cyc_n;
        intx = 1'($urandom_range(0, 1));
        cyc();
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_gnt", 32'(gnt), 32'd0);
        chk("post_ack", 32'(ack), 32'd0);
        chk("post_load", 32'(tx_load), 32'd0);
        chk("post_id_held", 32'(gnt_id), 32'(id));
        chk("post_data_held", 32'(tx_data), 32'(byt));
        m_last = id;
    endtask

    initial begin
        int         err;
        logic [3:0] r;
        logic [31:0] d;
        logic [1:0] id;
        int         gap;
        int         drop;

        tbl[0]  = '{4'b1111, 32'hD4C3B2A1, 0, 1'b0, 1'b0, 3, -1, 2'd0, 8'hA1};
        tbl[1]  = '{4'b1111, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 3, -1, 2'd1, 8'hB2};
        tbl[2]  = '{4'b1111, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 3, -1, 2'd2, 8'hC3};
        tbl[3]  = '{4'b1111, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 3, -1, 2'd3, 8'hD4};
        tbl[4]  = '{4'b1111, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 3, -1, 2'd0, 8'hA1};
        tbl[5]  = '{4'b0100, 32'h11A52233, 3, 1'b0, 1'b0, 16, -1, 2'd2, 8'hA5};
        tbl[6]  = '{4'b1010, 32'hD4C3B2A1, 2, 1'b0, 1'b0, 3, -1, 2'd3, 8'hD4};
        tbl[7]  = '{4'b1010, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 3, -1, 2'd1, 8'hB2};
        tbl[8]  = '{4'b1010, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 3, -1, 2'd3, 8'hD4};
        tbl[9]  = '{4'b1010, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 3, -1, 2'd1, 8'hB2};
        tbl[10] = '{4'b1001, 32'hD4C3B2A1, 1, 1'b0, 1'b0, 2, -1, 2'd3, 8'hD4};
        tbl[11] = '{4'b1001, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 2, -1, 2'd0, 8'hA1};
        tbl[12] = '{4'b0001, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 2, -1, 2'd0, 8'hA1};
        tbl[13] = '{4'b0001, 32'h000000E7, 2, 1'b0, 1'b1, 2, -1, 2'd0, 8'hE7};
        tbl[14] = '{4'b0001, 32'h0000003C, 2, 1'b0, 1'b0, 2, 3, 2'd0, 8'h3C};
        tbl[15] = '{4'b0110, 32'hD4C3B2A1, 1, 1'b0, 1'b0, 3, -1, 2'd1, 8'hB2};
        tbl[16] = '{4'b0110, 32'hD4C3B2A1, 0, 1'b1, 1'b0, 3, -1, 2'd2, 8'hC3};

        // Reset state, with requests already pending.
        reset    = 1'b0;
        intx     = 1'b0;
        req      = 4'b1111;
        req_data = 32'hD4C3B2A1;
        m_last   = 2'd3;
        repeat (3) cyc();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_id", 32'(gnt_id), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_load", 32'(tx_load), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_data", 32'(tx_data), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            do_frame(tbl[i].r, tbl[i].d, tbl[i].exp_id, tbl[i].exp_byte, tbl[i].gap,
                     tbl[i].b2b, tbl[i].spur, tbl[i].period, tbl[i].drop_at);
        end

        // Mid-frame reset: five ticks into SEND, then reset drops between clock edges.
        req      = 4'b0000;
        intx     = 1'b0;
        cyc();
        req      = 4'b0001;
        req_data = 32'h0000005C;
        cyc();
        chk("mr_load", 32'(tx_load), 32'd1);
        cyc();
        for (int p = 0; p < 5; p++) begin
            intx = 1'b1;
            cyc();
            intx = 1'b0;
            cyc();
        end
        chk("mr_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("mr_gnt", 32'(gnt), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_load0", 32'(tx_load), 32'd0);
        chk("mr_ack", 32'(ack), 32'd0);
        chk("mr_data", 32'(tx_data), 32'd0);
        chk("mr_id", 32'(gnt_id), 32'd0);
        err = 0;
        for (int c = 0; c < 4; c++) begin
            intx = 1'(c % 2);
            cyc();
            if (ack !== 4'b0000 || busy !== 1'b0 || gnt !== 4'b0000) err++;
        end
        chk("mr_held_quiet", 32'(err), 32'd0);
        intx   = 1'b0;
        reset  = 1'b1;
        m_last = 2'd3;
        do_frame(4'b0001, 32'h0000005C, 2'd0, 8'h5C, 0, 1'b0, 1'b0, 2, -1);

        // Random frames against the reference arbitration model.
        for (int f = 0; f < 40; f++) begin
            r    = 4'($urandom_range(1, 15));
            d    = $urandom;
            id   = model_pick(r, m_last);
            gap  = $urandom_range(0, 2);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
            do_frame(r, d, id, 8'(d >> (8 * int'(id))), gap, (gap == 0), 1'($urandom_range(0, 1)), 0, drop);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
